// File: rtl/pc_unit.sv
// Fetch-side program counter: prioritised redirects, optional compressed stepping,
// valid/ready fetch handshake and halt/resume control.
module pc_unit #(
  parameter int                XLEN      = 32,
  parameter logic [XLEN-1:0]   RESET_VEC = 32'h0100_0000,
  parameter logic [XLEN-1:0]   TRAP_VEC  = 32'h0100_0100,
  parameter int                ALLOW_C   = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_ready,
  input  logic            step_c,
  input  logic            branch,
  input  logic [XLEN-1:0] imm,
  input  logic            redir_jalr,
  input  logic [XLEN-1:0] jalr_base,
  input  logic            redir_trap,
  input  logic            halt,
  input  logic            resume,
  output logic            fetch_valid,
  output logic [XLEN-1:0] instr_addr,
  output logic [XLEN-1:0] pc_plus,
  output logic            misalign,
  output logic [1:0]      state
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    SPARE = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] ALIGN_MASK = (ALLOW_C != 0) ?
      ~{{(XLEN-1){1'b0}}, 1'b1} : ~{{(XLEN-2){1'b0}}, 2'b11};

  state_t          cur_state;
  state_t          nxt_state;
  logic [XLEN-1:0] addr_next;
  logic [XLEN-1:0] step;
  logic [XLEN-1:0] jalr_tgt;
  logic            jalr_bad;
  logic            mis_next;
  logic            fv_next;

  assign step     = ((ALLOW_C != 0) && step_c) ? XLEN'(3'd2) : XLEN'(3'd4);
  assign pc_plus  = instr_addr + step;
  assign jalr_tgt = (jalr_base + imm) & ~{{(XLEN-1){1'b0}}, 1'b1};
  // With bit 0 already cleared, only a set bit 1 can violate 4-byte alignment.
  assign jalr_bad = (ALLOW_C == 0) && jalr_tgt[1];
  assign state    = cur_state;

  // Next-state and next-address selection.
  always_comb begin
    nxt_state = cur_state;
    addr_next = instr_addr;
    mis_next  = 1'b0;
    case (cur_state)
      BOOT: nxt_state = RUN;
      RUN: begin
        if (redir_trap) begin
          addr_next = TRAP_VEC;
        end else if (redir_jalr) begin
          if (jalr_bad) begin
            addr_next = TRAP_VEC;
            mis_next  = 1'b1;
          end else begin
            addr_next = jalr_tgt;
          end
        end else if (branch) begin
          addr_next = instr_addr + (imm & ALIGN_MASK);
        end else if (fetch_valid && fetch_ready) begin
          addr_next = pc_plus;
        end else begin
          addr_next = instr_addr;
        end
        if (halt) begin
          nxt_state = HALT;
        end else begin
          nxt_state = RUN;
        end
      end
      HALT: begin
        if (redir_trap) begin
          addr_next = TRAP_VEC;
          nxt_state = RUN;
        end else if (resume && !halt) begin
          nxt_state = RUN;
        end else begin
          nxt_state = HALT;
        end
      end
      default: nxt_state = BOOT;
    endcase
    fv_next = (nxt_state == RUN);
  end

  // State, address and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state   <= BOOT;
      instr_addr  <= RESET_VEC;
      misalign    <= 1'b0;
      fetch_valid <= 1'b0;
    end else begin
      cur_state   <= nxt_state;
      instr_addr  <= addr_next;
      misalign    <= mis_next;
      fetch_valid <= fv_next;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: two instances (ALLOW_C=0 and ALLOW_C=1) share the stimulus and are
// checked against a reference model of the fetch rules, with directed then random steps.
module tb_pc_unit;

  localparam logic [31:0] RV = 32'h0100_0000;
  localparam logic [31:0] TV = 32'h0100_0100;

  logic        clk;
  logic        rst;
  logic        fetch_ready, step_c, branch, redir_jalr, redir_trap, halt, resume;
  logic [31:0] imm, jalr_base;
  logic        fv  [2];
  logic [31:0] ia  [2];
  logic [31:0] pp  [2];
  logic        mis [2];
  logic [1:0]  st  [2];

  logic [31:0] m_addr  [2];
  logic [1:0]  m_state [2];
  logic        m_mis   [2];

  int vectors;
  int miscompares;

  pc_unit #(.XLEN(32), .RESET_VEC(RV), .TRAP_VEC(TV), .ALLOW_C(0)) dut0 (
    .clk(clk), .rst(rst), .fetch_ready(fetch_ready), .step_c(step_c), .branch(branch),
    .imm(imm), .redir_jalr(redir_jalr), .jalr_base(jalr_base), .redir_trap(redir_trap),
    .halt(halt), .resume(resume), .fetch_valid(fv[0]), .instr_addr(ia[0]),
    .pc_plus(pp[0]), .misalign(mis[0]), .state(st[0])
  );

  pc_unit #(.XLEN(32), .RESET_VEC(RV), .TRAP_VEC(TV), .ALLOW_C(1)) dut1 (
    .clk(clk), .rst(rst), .fetch_ready(fetch_ready), .step_c(step_c), .branch(branch),
    .imm(imm), .redir_jalr(redir_jalr), .jalr_base(jalr_base), .redir_trap(redir_trap),
    .halt(halt), .resume(resume), .fetch_valid(fv[1]), .instr_addr(ia[1]),
    .pc_plus(pp[1]), .misalign(mis[1]), .state(st[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_addr[k]  = RV;
      m_state[k] = 2'd0;
      m_mis[k]   = 1'b0;
    end
  endtask

  // Reference: one clock edge of the fetch rules, k doubles as the ALLOW_C setting.
  task automatic model_edge();
    logic [31:0] t;
    logic [31:0] amask;
    logic [31:0] stp;
    for (int k = 0; k < 2; k++) begin
      amask = (k == 1) ? 32'hFFFF_FFFE : 32'hFFFF_FFFC;
      stp   = (k == 1 && step_c) ? 32'd2 : 32'd4;
      if (rst) begin
        m_addr[k] = RV; m_state[k] = 2'd0; m_mis[k] = 1'b0;
      end else begin
        m_mis[k] = 1'b0;
        if (m_state[k] == 2'd0) begin
          m_state[k] = 2'd1;
        end else if (m_state[k] == 2'd1) begin
          if (redir_trap) m_addr[k] = TV;
          else if (redir_jalr) begin
            t = (jalr_base + imm) & 32'hFFFF_FFFE;
            if (k == 0 && (t % 4) != 0) begin
              m_addr[k] = TV; m_mis[k] = 1'b1;
            end else m_addr[k] = t;
          end
          else if (branch) m_addr[k] = m_addr[k] + (imm & amask);
          else if (fetch_ready) m_addr[k] = m_addr[k] + stp;
          m_state[k] = halt ? 2'd2 : 2'd1;
        end else begin
          if (redir_trap) begin
            m_addr[k] = TV; m_state[k] = 2'd1;
          end else if (resume && !halt) m_state[k] = 2'd1;
        end
      end
    end
  endtask

  task automatic check_all(input string ctx);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s.addr%0d", ctx, k), ia[k], m_addr[k]);
      chk($sformatf("%s.state%0d", ctx, k), {30'd0, st[k]}, {30'd0, m_state[k]});
      chk($sformatf("%s.valid%0d", ctx, k), {31'd0, fv[k]}, {31'd0, (m_state[k] == 2'd1)});
      chk($sformatf("%s.mis%0d", ctx, k), {31'd0, mis[k]}, {31'd0, m_mis[k]});
      chk($sformatf("%s.plus%0d", ctx, k), pp[k],
          m_addr[k] + ((k == 1 && step_c) ? 32'd2 : 32'd4));
    end
  endtask

  task automatic cyc(input string ctx);
    @(posedge clk);
    model_edge();
    #1;
    check_all(ctx);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; fetch_ready = 1'b1; step_c = 1'b0; branch = 1'b0; redir_jalr = 1'b0;
    redir_trap = 1'b0; halt = 1'b0; resume = 1'b0; imm = 32'd0; jalr_base = 32'd0;
    model_reset();
    cyc("rst"); cyc("rst");
    chk("reset_addr", ia[0], RV);
    chk("reset_state", {30'd0, st[0]}, 32'd0);
    rst = 1'b0;
    #1; check_all("boot");
    chk("boot_valid", {31'd0, fv[0]}, 32'd0);
    cyc("run0"); chk("run0_addr", ia[0], 32'h0100_0000);
    chk("run0_valid", {31'd0, fv[0]}, 32'd1);
    cyc("run1"); chk("run1_addr", ia[0], 32'h0100_0004);
    cyc("run2"); chk("run2_addr", ia[0], 32'h0100_0008);
    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc("stall"); chk("stall_addr", ia[0], 32'h0100_0008);
    end
    fetch_ready = 1'b1;
    cyc("unstall"); chk("unstall_addr", ia[0], 32'h0100_000C);
    cyc("run3"); chk("run3_addr", ia[0], 32'h0100_0010);
    redir_trap = 1'b1; redir_jalr = 1'b1; branch = 1'b1; jalr_base = 32'h0000_5000;
    cyc("prio"); chk("prio_addr", ia[0], TV);
    redir_trap = 1'b0; redir_jalr = 1'b0; imm = 32'hFFFF_FFF3;
    cyc("brmask"); chk("brmask0", ia[0], 32'h0100_00F0); chk("brmask1", ia[1], 32'h0100_00F2);
    branch = 1'b0; redir_jalr = 1'b1; jalr_base = 32'h0000_2000; imm = 32'd2;
    cyc("jalr"); chk("jalr0_addr", ia[0], TV); chk("jalr0_mis", {31'd0, mis[0]}, 32'd1);
    chk("jalr1_addr", ia[1], 32'h0000_2002); chk("jalr1_mis", {31'd0, mis[1]}, 32'd0);
    redir_jalr = 1'b0; fetch_ready = 1'b0;
    cyc("mis_end"); chk("mis_pulse", {31'd0, mis[0]}, 32'd0);
    step_c = 1'b1; fetch_ready = 1'b1;
    #1; chk("plus_c", pp[1], 32'h0000_2004); chk("plus_noc", pp[0], TV + 32'd4);
    cyc("stepc"); chk("stepc_addr", ia[1], 32'h0000_2004);
    step_c = 1'b0; redir_jalr = 1'b1; jalr_base = 32'h0100_0020; imm = 32'd0;
    cyc("to20");
    redir_jalr = 1'b0; halt = 1'b1;
    cyc("halt"); chk("halt_addr", ia[0], 32'h0100_0024); chk("halt_state", {30'd0, st[0]}, 32'd2);
    chk("halt_valid", {31'd0, fv[0]}, 32'd0);
    halt = 1'b0; branch = 1'b1; imm = 32'h0000_0100;
    cyc("halt_br"); chk("halt_br_addr", ia[0], 32'h0100_0024);
    branch = 1'b0; halt = 1'b1; resume = 1'b1;
    cyc("halt_both"); chk("halt_both_state", {30'd0, st[0]}, 32'd2);
    halt = 1'b0;
    cyc("resume"); chk("resume_state", {30'd0, st[0]}, 32'd1);
    chk("resume_addr", ia[0], 32'h0100_0024);
    resume = 1'b0;
    cyc("post_resume"); chk("post_resume_addr", ia[0], 32'h0100_0028);
    halt = 1'b1;
    cyc("halt2");
    halt = 1'b0; fetch_ready = 1'b0;
    #2 rst = 1'b1;
    #1 model_reset();
    check_all("arst_halt");
    chk("arst_addr", ia[0], 32'h0100_0000); chk("arst_state", {30'd0, st[0]}, 32'd0);
    cyc("arst_hold");

    for (int i = 0; i < 600; i++) begin
      if (rst) rst = 1'b0;
      fetch_ready = ($urandom_range(0, 3) != 0);
      step_c      = $urandom_range(0, 1) == 1;
      redir_trap  = ($urandom_range(0, 15) == 0);
      redir_jalr  = ($urandom_range(0, 7) == 0);
      branch      = ($urandom_range(0, 5) == 0);
      halt        = ($urandom_range(0, 15) == 0);
      resume      = ($urandom_range(0, 3) == 0);
      imm         = $urandom;
      jalr_base   = $urandom;
      if ($urandom_range(0, 99) == 0) begin
        #2 rst = 1'b1;
        #1 model_reset();
        check_all("rnd_arst");
      end
      cyc("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
